// File: rtl/irq_stim_pkg.sv
// Shared types and constants for the RI5CY bench interrupt stimulus generator.
package irq_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WAIT    = 2'b01,
    ST_ASSERT  = 2'b10,
    ST_HOLDOFF = 2'b11
  } irq_stim_state_e;

  // Encoding 2'b11 is deliberately absent and behaves like MODE_OFF.
  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_RANDOM = 2'b01,
    MODE_FIXED  = 2'b10
  } irq_stim_mode_e;

  // Galois form of x^32 + x^22 + x^2 + x + 1 for a right-shifting register.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_RST  = 32'h0000_0001;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/irq_stim_lfsr.sv
// 32-bit Galois LFSR with seed load; a zero seed is replaced by 1 so the register never locks up.
module irq_stim_lfsr
  import irq_stim_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        seed_load,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            state <= LFSR_RST;
    else if (seed_load) state <= (seed == '0) ? LFSR_RST : seed;
    else if (enable)    state <= lfsr_step(state);
  end

endmodule

// File: rtl/riscv_irq_stim_gen.sv
// Bench-side interrupt stimulus generator: one IRQ at a time, random or fixed delay/ID, handshake stats.
// Define IRQ_STIM_TIMEOUT_EN to withdraw unacknowledged IRQs after TIMEOUT cycles (counted as dropped).
module riscv_irq_stim_gen
  import irq_stim_pkg::*;
#(
  parameter int DLY_W   = 16,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024,
  parameter int HOLDOFF = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [1:0]       mode_i,
  input  logic             seed_load_i,
  input  logic [31:0]      seed_i,
  input  logic [DLY_W-1:0] min_delay_i,
  input  logic [DLY_W-1:0] max_delay_i,
  input  logic [4:0]       id_min_i,
  input  logic [4:0]       id_max_i,
  input  logic [DLY_W-1:0] fixed_delay_i,
  input  logic [4:0]       fixed_id_i,
  output logic             irq_o,
  output logic [4:0]       irq_id_o,
  input  logic             irq_ack_i,
  input  logic [4:0]       irq_ack_id_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] raised_cnt_o,
  output logic [CNT_W-1:0] acked_cnt_o,
  output logic [CNT_W-1:0] dropped_cnt_o,
  output logic             mismatch_o
);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  if (DLY_W < 1 || DLY_W > 32 || CNT_W < 1 || TIMEOUT < 1 || HOLDOFF < 0) begin : g_bad_param
    $fatal(1, "riscv_irq_stim_gen: unsupported parameter set");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [31:0]      lfsr;
  logic             lfsr_unused;
  irq_stim_state_e  state;
  logic [DLY_W-1:0] wait_cnt;
  logic [4:0]       id_q;
  logic [HW-1:0]    ho_cnt;

  logic             draw_go;
  logic             is_fixed;
  logic [DLY_W:0]   dly_span;
  logic [5:0]       id_span;
  logic [DLY_W-1:0] rnd_dly;
  logic [4:0]       rnd_id;
  logic [DLY_W-1:0] draw_dly;
  logic [4:0]       draw_id;

  irq_stim_lfsr u_lfsr (
    .clk       (clk_i),
    .rst       (rst_i),
    .enable    (enable_i),
    .seed_load (seed_load_i),
    .seed      (seed_i),
    .state     (lfsr)
  );

  // Only the low delay bits and [20:16] feed the draw; the rest of the state just cycles.
  assign lfsr_unused = ^lfsr;

  assign is_fixed = (mode_i == 2'(MODE_FIXED));
  assign draw_go  = enable_i && ((mode_i == 2'(MODE_RANDOM)) || is_fixed);

  // Spans are one bit wider than the bounds so a full-range window does not wrap to zero.
  always_comb begin
    dly_span = '0;
    id_span  = '0;
    rnd_dly  = min_delay_i;
    rnd_id   = id_min_i;
    if (max_delay_i >= min_delay_i) begin
      dly_span = {1'b0, max_delay_i} - {1'b0, min_delay_i} + {{DLY_W{1'b0}}, 1'b1};
      rnd_dly  = min_delay_i + DLY_W'({1'b0, lfsr[DLY_W-1:0]} % dly_span);
    end
    if (id_max_i >= id_min_i) begin
      id_span = {1'b0, id_max_i} - {1'b0, id_min_i} + 6'd1;
      rnd_id  = id_min_i + 5'({1'b0, lfsr[20:16]} % id_span);
    end
  end

  assign draw_dly = is_fixed ? fixed_delay_i : rnd_dly;
  assign draw_id  = is_fixed ? fixed_id_i    : rnd_id;

`ifdef IRQ_STIM_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0]    tmo_cnt;
  logic [CNT_W-1:0] dropped_q;
  assign dropped_cnt_o = dropped_q;
`else
  assign dropped_cnt_o = '0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      id_q         <= '0;
      ho_cnt       <= '0;
      irq_o        <= 1'b0;
      irq_id_o     <= '0;
      busy_o       <= 1'b0;
      raised_cnt_o <= '0;
      acked_cnt_o  <= '0;
      mismatch_o   <= 1'b0;
`ifdef IRQ_STIM_TIMEOUT_EN
      tmo_cnt      <= '0;
      dropped_q    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (draw_go) begin
            state    <= ST_WAIT;
            busy_o   <= 1'b1;
            wait_cnt <= draw_dly;
            id_q     <= draw_id;
          end
        end
        ST_WAIT: begin
          if (!enable_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else if (wait_cnt == '0) begin
            state        <= ST_ASSERT;
            irq_o        <= 1'b1;
            irq_id_o     <= id_q;
            raised_cnt_o <= sat_inc(raised_cnt_o);
`ifdef IRQ_STIM_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
          end else begin
            wait_cnt <= wait_cnt - {{(DLY_W-1){1'b0}}, 1'b1};
          end
        end
        ST_ASSERT: begin
          // Ack is checked first so a same-cycle timeout never counts as a drop.
          if (irq_ack_i) begin
            irq_o       <= 1'b0;
            acked_cnt_o <= sat_inc(acked_cnt_o);
            if (irq_ack_id_i != irq_id_o) mismatch_o <= 1'b1;
            ho_cnt <= '0;
            if (HOLDOFF == 0) begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end else begin
              state <= ST_HOLDOFF;
            end
          end
`ifdef IRQ_STIM_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            irq_o     <= 1'b0;
            dropped_q <= sat_inc(dropped_q);
            ho_cnt    <= '0;
            if (HOLDOFF == 0) begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end else begin
              state <= ST_HOLDOFF;
            end
          end else begin
            tmo_cnt <= tmo_cnt + {{(TW-1){1'b0}}, 1'b1};
          end
`endif
        end
        ST_HOLDOFF: begin
          if (ho_cnt == HW'(HOLDOFF - 1)) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else begin
            ho_cnt <= ho_cnt + {{(HW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_irq_stim_gen.sv
// Directed bench for riscv_irq_stim_gen: expected raises are queued at draw time and checked at the rise.
module tb_riscv_irq_stim_gen;

  localparam int DLY_W   = 16;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 1024;
  localparam int HOLDOFF = 2;
  localparam logic [1:0] M_RANDOM = 2'b01;
  localparam logic [1:0] M_FIXED  = 2'b10;

  typedef struct {
    int         rise;
    logic [4:0] id;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             seed_load = 1'b0;
  logic [31:0]      seed = '0;
  logic [DLY_W-1:0] min_delay = '0, max_delay = '0, fixed_delay = '0;
  logic [4:0]       id_min = '0, id_max = '0, fixed_id = '0;
  logic             irq_ack = 1'b0;
  logic [4:0]       irq_ack_id = '0;
  logic             irq_o, busy_o, mismatch_o;
  logic [4:0]       irq_id_o;
  logic [CNT_W-1:0] raised_cnt_o, acked_cnt_o, dropped_cnt_o;

  riscv_irq_stim_gen #(.DLY_W(DLY_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .HOLDOFF(HOLDOFF)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .mode_i        (mode),
    .seed_load_i   (seed_load),
    .seed_i        (seed),
    .min_delay_i   (min_delay),
    .max_delay_i   (max_delay),
    .id_min_i      (id_min),
    .id_max_i      (id_max),
    .fixed_delay_i (fixed_delay),
    .fixed_id_i    (fixed_id),
    .irq_o         (irq_o),
    .irq_id_o      (irq_id_o),
    .irq_ack_i     (irq_ack),
    .irq_ack_id_i  (irq_ack_id),
    .busy_o        (busy_o),
    .raised_cnt_o  (raised_cnt_o),
    .acked_cnt_o   (acked_cnt_o),
    .dropped_cnt_o (dropped_cnt_o),
    .mismatch_o    (mismatch_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: right-shifting Galois register for x^32+x^22+x^2+x+1.
  logic [31:0] m_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 32'h1;
    else if (seed_load) m_lfsr <= (seed == 32'h0) ? 32'h1 : seed;
    else if (enable) m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h8020_0003) : (m_lfsr >> 1);
  end

  exp_t       sb[$];
  int         n_vec = 0, n_err = 0;
  int         exp_raised = 0, exp_acked = 0, exp_dropped = 0;
  logic [4:0] last_id = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int rise, input logic [4:0] id);
    exp_t e;
    e.rise = rise;
    e.id   = id;
    sb.push_back(e);
  endtask

  task automatic wait_rise(input string tag);
    exp_t e;
    int   n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!irq_o && n < 3000);
    e = sb.pop_front();
    last_id = e.id;
    chk({tag, "_irq"},  irq_o, 1'b1);
    chk({tag, "_rise"}, cyc, e.rise);
    chk({tag, "_id"},   irq_id_o, e.id);
  endtask

  task automatic ack_now(input logic [4:0] id, input logic keep_en);
    irq_ack    = 1'b1;
    irq_ack_id = id;
    enable     = keep_en;
    @(negedge clk);
    irq_ack = 1'b0;
    exp_acked++;
    chk("ack_fall", irq_o, 1'b0);
    chk("acked_cnt", acked_cnt_o, exp_acked);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_raised"},  raised_cnt_o,  exp_raised);
    chk({tag, "_acked"},   acked_cnt_o,   exp_acked);
    chk({tag, "_dropped"}, dropped_cnt_o, exp_dropped);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_irq", irq_o, 1'b0);
    chk("rst_id", irq_id_o, 5'd0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_mismatch", mismatch_o, 1'b0);
    chk_counts("rst");
    rst = 1'b0;
    @(negedge clk);

    // FIXED delay 5, ID 11, ack three cycles after the raise
    mode = M_FIXED; fixed_delay = 16'd5; fixed_id = 5'd11; enable = 1'b1;
    push(cyc + 7, 5'd11);
    @(negedge clk);
    chk("fix1_busy", busy_o, 1'b1);
    wait_rise("fix1");
    exp_raised++;
    repeat (3) @(negedge clk);
    chk("fix1_hold", irq_o, 1'b1);
    chk("fix1_hold_id", irq_id_o, 5'd11);
    ack_now(5'd11, 1'b0);
    chk("fix1_mismatch", mismatch_o, 1'b0);
    chk_counts("fix1");
    repeat (4) @(negedge clk);
    chk("fix1_idle", busy_o, 1'b0);
    chk("fix1_id_kept", irq_id_o, 5'd11);

    // Ack while idle must be ignored
    irq_ack = 1'b1; irq_ack_id = 5'd3;
    @(negedge clk);
    irq_ack = 1'b0;
    @(negedge clk);
    chk_counts("stray_ack");
    chk("stray_mismatch", mismatch_o, 1'b0);

    // Wrong ack ID sets sticky mismatch; it survives a following clean IRQ
    enable = 1'b1;
    push(cyc + 7, 5'd11);
    wait_rise("mis1");
    exp_raised++;
    push(cyc + 1 + HOLDOFF + 5 + 2, 5'd11);
    ack_now(5'd12, 1'b1);
    chk("mis_set", mismatch_o, 1'b1);
    wait_rise("mis2");
    exp_raised++;
    ack_now(5'd11, 1'b0);
    chk("mis_sticky", mismatch_o, 1'b1);
    chk_counts("mis");
    repeat (4) @(negedge clk);

    // Dropping enable during WAIT abandons the IRQ
    fixed_delay = 16'd20; enable = 1'b1;
    repeat (5) @(negedge clk);
    chk("wait_busy", busy_o, 1'b1);
    enable = 1'b0;
    @(negedge clk);
    chk("wait_abort_busy", busy_o, 1'b0);
    chk("wait_abort_irq", irq_o, 1'b0);
    chk_counts("wait_abort");

    // Mode 11 acts as OFF
    mode = 2'b11; enable = 1'b1;
    repeat (4) @(negedge clk);
    chk("mode3_busy", busy_o, 1'b0);
    enable = 1'b0;
    @(negedge clk);

    // Inverted RANDOM bounds fall back to the minimum
    mode = M_RANDOM; min_delay = 16'd6; max_delay = 16'd2; id_min = 5'd9; id_max = 5'd1;
    enable = 1'b1;
    push(cyc + 8, 5'd9);
    wait_rise("inv");
    exp_raised++;
    ack_now(5'd9, 1'b0);
    repeat (4) @(negedge clk);

    // Zero delay: raise two cycles after the draw
    mode = M_FIXED; fixed_delay = 16'd0; fixed_id = 5'd31; enable = 1'b1;
    push(cyc + 2, 5'd31);
    wait_rise("d0");
    exp_raised++;
    ack_now(5'd31, 1'b0);
    repeat (4) @(negedge clk);

`ifdef IRQ_STIM_TIMEOUT_EN
    begin
      int r, n;
      fixed_delay = 16'd1; fixed_id = 5'd7; enable = 1'b1;
      push(cyc + 3, 5'd7);
      wait_rise("tmo");
      exp_raised++;
      r = cyc;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (irq_o && n < TIMEOUT + 50);
      chk("tmo_width", cyc - r, TIMEOUT);
      exp_dropped++;
      chk_counts("tmo");
      push(r + TIMEOUT + HOLDOFF + 3, 5'd7);
      wait_rise("tmo_next");
      exp_raised++;
      repeat (TIMEOUT - 1) @(negedge clk);
      chk("tmo_last_high", irq_o, 1'b1);
      ack_now(5'd7, 1'b0);
      chk_counts("tmo_tie");
      repeat (4) @(negedge clk);
    end
`else
    fixed_delay = 16'd1; fixed_id = 5'd7; enable = 1'b1;
    push(cyc + 3, 5'd7);
    wait_rise("notmo");
    exp_raised++;
    repeat (TIMEOUT + 50) @(negedge clk);
    chk("notmo_held", irq_o, 1'b1);
    ack_now(5'd7, 1'b0);
    chk_counts("notmo");
    repeat (4) @(negedge clk);
`endif

    // RANDOM, seed 0xACE1, delays 3..10, IDs 4..7, immediate ack
    seed = 32'hACE1; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    mode = M_RANDOM; min_delay = 16'd3; max_delay = 16'd10; id_min = 5'd4; id_max = 5'd7;
    enable = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      int t, d;
      logic [4:0] id;
      t  = cyc;
      d  = 3 + int'(m_lfsr[15:0] % 16'd8);
      id = 5'd4 + 5'(m_lfsr[20:16] % 5'd4);
      push(t + d + 2, id);
      wait_rise("rnd");
      chk("rnd_dly_range", ((cyc - t - 2) >= 3) && ((cyc - t - 2) <= 10), 1'b1);
      chk("rnd_id_range", (irq_id_o >= 5'd4) && (irq_id_o <= 5'd7), 1'b1);
      exp_raised++;
      ack_now(last_id, i != 999);
      if (i != 999) repeat (HOLDOFF) @(negedge clk);
    end
    chk_counts("rnd");
    repeat (4) @(negedge clk);

    // Reset in ASSERT clears everything at once, then generation resumes
    mode = M_FIXED; fixed_delay = 16'd2; fixed_id = 5'd5; enable = 1'b1;
    push(cyc + 4, 5'd5);
    wait_rise("pre_rst");
    exp_raised++;
    rst = 1'b1;
    #1;
    exp_raised = 0; exp_acked = 0; exp_dropped = 0;
    chk("midrst_irq", irq_o, 1'b0);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_mismatch", mismatch_o, 1'b0);
    chk_counts("midrst");
    @(negedge clk);
    rst = 1'b0;
    push(cyc + 4, 5'd5);
    wait_rise("post_rst");
    exp_raised++;
    ack_now(5'd5, 1'b0);
    chk_counts("post_rst");
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_irq_stim_gen.md
# riscv_irq_stim_gen

- Bench-side interrupt stimulus generator in the RI5CY core testbench.
- Drives the core's level-sensitive interrupt inputs (`irq_i`, `irq_id_i`) and consumes its acknowledge outputs (`irq_ack_o`, `irq_id_o`).
- Issues one interrupt at a time with LFSR-randomised or fixed delay and ID, holds it until acknowledged or timed out, and keeps handshake statistics for the checker.
- Not intended for synthesis; `%` operators are permitted.

## Interface
- `DLY_W`, 16, width of delay fields.
- `CNT_W`, 32, width of statistic counters.
- `TIMEOUT`, 1024, cycles an asserted IRQ waits for ack before withdrawal.
- `HOLDOFF`, 2, idle cycles after each completed IRQ.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `enable_i`  in  1  generator enable.
- `mode_i`  in  2  00 OFF, 01 RANDOM, 10 FIXED, 11 treated as OFF.
- `seed_load_i`  in  1  pulse: load `seed_i` into LFSR.
- `seed_i`  in  32  LFSR seed.
- `min_delay_i` / `max_delay_i`  in  DLY_W  RANDOM delay bounds, inclusive.
- `id_min_i` / `id_max_i`  in  5  RANDOM ID bounds, inclusive.
- `fixed_delay_i`  in  DLY_W  FIXED-mode delay.
- `fixed_id_i`  in  5  FIXED-mode ID.
- `irq_o`  out  1  to core `irq_i`.
- `irq_id_o`  out  5  to core `irq_id_i`.
- `irq_ack_i`  in  1  from core `irq_ack_o`.
- `irq_ack_id_i`  in  5  from core `irq_id_o`.
- `busy_o`  out  1  state ≠ IDLE.
- `raised_cnt_o`, `acked_cnt_o`, `dropped_cnt_o`  out  CNT_W  statistics.
- `mismatch_o`  out  1  sticky: ack ID ≠ issued ID.

## Operation
- Reset: all outputs 0; LFSR = 32'h1; state IDLE.
- LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1.
  - Advances every cycle while `enable_i`=1.
  - `seed_load_i` has priority over advancing; a seed of 0 loads 1.
- States: IDLE → WAIT → ASSERT → HOLDOFF → IDLE.
- IDLE: if `enable_i` and mode is RANDOM or FIXED, draw delay and ID, go WAIT.
  - `mode_i` is sampled only in IDLE.
- Draw rules, RANDOM:
  - `delay = min + lfsr[DLY_W-1:0] % (max-min+1)`
  - `id = id_min + lfsr[20:16] % (id_max-id_min+1)`
  - If max < min, use min.
  - Draw values are latched into registers.
- Draw rules, FIXED: use `fixed_delay_i` / `fixed_id_i`.
- WAIT: down-counter from delay.
  - At 0: set `irq_o`=1, `irq_id_o`=id, `raised_cnt`+1, go ASSERT.
  - `enable_i`=0 in WAIT returns to IDLE without raising.
- ASSERT: `irq_o` and `irq_id_o` held stable.
  - Ack (`irq_ack_i`=1): clear `irq_o`, `acked_cnt`+1; if `irq_ack_id_i` ≠ `irq_id_o`, set `mismatch_o`; go HOLDOFF.
  - Timeout, only with the configuration macro defined (see Configuration): clear `irq_o`, `dropped_cnt`+1, go HOLDOFF.
  - `enable_i`=0 does not withdraw an asserted IRQ.
- HOLDOFF: count HOLDOFF cycles, then go IDLE.
- Counters saturate at all-ones.
- Simultaneous ack and timeout: ack wins, no drop counted.
- Ack outside ASSERT: ignored, no counter change.
- Reset mid-operation: immediate return to reset values, including counters and `mismatch_o`.

## Timing
- All outputs registered.
- Delay d drawn in IDLE at cycle T: `irq_o` rises at T+d+2 (one cycle IDLE→WAIT, d WAIT cycles, one cycle to register).
- Ack sampled high at cycle N: `irq_o` low at N+1; counters update at N+1.
- Timeout: `irq_o` low exactly TIMEOUT cycles after it rose.
- Next draw occurs HOLDOFF+1 cycles after deassertion.
- `irq_id_o` holds its last value after deassertion until the next raise.

## Configuration
- `IRQ_STIM_TIMEOUT_EN` defined: TIMEOUT counter is compiled in; unacknowledged IRQs are withdrawn and counted in `dropped_cnt_o`.
- `IRQ_STIM_TIMEOUT_EN` undefined: no timeout logic; ASSERT waits for ack indefinitely; `dropped_cnt_o` is tied to 0.

## Structure
- Package `irq_stim_pkg`:
  - `irq_stim_state_e` (IDLE, WAIT, ASSERT, HOLDOFF).
  - `irq_stim_mode_e` (OFF, RANDOM, FIXED).
  - LFSR tap constant 32'h8020_0003.
  - LFSR reset value 32'h1.
- One sub-module: `irq_stim_lfsr` (seed load, enable, 32-bit state out).

## Test plan
- FIXED, delay 5, ID 11, core acks 3 cycles after raise with ID 11 → `irq_o` rises 7 cycles after leaving IDLE; `irq_id_o`=11; `acked_cnt`=1; `mismatch_o`=0.
- FIXED, ack with ID 12 while issued ID is 11 → `irq_o` drops next cycle; `mismatch_o`=1 and stays 1 through later IRQs.
- Macro defined, TIMEOUT=1024, no ack → `irq_o` high exactly 1024 cycles; `dropped_cnt`=1; next draw after HOLDOFF.
- RANDOM, seed 0xACE1, min 3, max 10, IDs 4..7, 1000 IRQs with immediate ack → every delay in 3..10, every ID in 4..7; raised=acked=1000.
- Ack and timeout in the same cycle → `acked_cnt`+1, `dropped_cnt` unchanged.
- `rst_i` pulsed during ASSERT → `irq_o`=0 and all counters 0 in the same cycle; after release, `enable_i`=1 resumes from IDLE.
